// File: rtl/mult_writeback_unit.sv
// rtl/mult_writeback_unit.sv - iterative 32x32 shift-add multiplier driving the register file write port
// Optional macro: MULT_HI_WRITE_EN (adds a WB_HI cycle that writes product[63:32] to DestReg+1)
module mult_writeback_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  Signed,
    input  logic [WIDTH-1:0]      OperandA,
    input  logic [WIDTH-1:0]      OperandB,
    input  logic [ADDR_WIDTH-1:0] DestReg,
    output logic                  Busy,
    output logic                  Done,
    output logic [WIDTH-1:0]      WriteData,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic                  RegWrite
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                  regwrite_q, regwrite_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  done_q, done_d;

    logic [WIDTH-1:0]      mag_a, mag_b;
    logic [WIDTH:0]        sum;
    logic [2*WIDTH-1:0]    acc_step;
    logic [2*WIDTH-1:0]    product;

    // Operand magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude
    always_comb begin
        mag_a = (Signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
        mag_b = (Signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;
    end

    // One shift-add iteration: 33-bit add into the upper half keeps the carry, then shift right
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {sum, acc_q[WIDTH-1:1]};
        product  = neg_q ? -acc_step : acc_step;
    end

    // Next-state and registered-output logic; write port is idle unless in a writeback cycle
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        dest_d     = dest_q;
        regwrite_d = 1'b0;
        wreg_d     = '0;
        wdata_d    = '0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    mcand_d = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    neg_d   = Signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                    dest_d  = DestReg;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Final iteration: hold the signed product and present the low word next cycle
                    acc_d      = product;
                    state_d    = WB_LO;
                    regwrite_d = 1'b1;
                    wreg_d     = dest_q;
                    wdata_d    = product[WIDTH-1:0];
`ifdef MULT_HI_WRITE_EN
                    done_d     = (dest_q == '1);
`else
                    done_d     = 1'b1;
`endif
                end
            end
            WB_LO: begin
                state_d = IDLE;
`ifdef MULT_HI_WRITE_EN
                // The top register has no successor; skip the high write rather than wrap to register 0
                if (dest_q != '1) begin
                    state_d    = WB_HI;
                    regwrite_d = 1'b1;
                    wreg_d     = dest_q + ADDR_WIDTH'(1);
                    wdata_d    = acc_q[2*WIDTH-1:WIDTH];
                    done_d     = 1'b1;
                end
`endif
            end
            WB_HI: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without a write
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            dest_q     <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            dest_q     <= dest_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign Busy          = (state_q != IDLE);
    assign Done          = done_q;
    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;

endmodule

// File: tb/tb_mult_writeback_unit.sv
// tb/tb_mult_writeback_unit.sv - directed table-driven bench for mult_writeback_unit
module tb_mult_writeback_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] OperandA = '0;
    logic [31:0] OperandB = '0;
    logic [4:0]  DestReg = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite;

    int total = 0;
    int bad   = 0;

    mult_writeback_unit #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Start         (Start),
        .Signed        (Signed),
        .OperandA      (OperandA),
        .OperandB      (OperandB),
        .DestReg       (DestReg),
        .Busy          (Busy),
        .Done          (Done),
        .WriteData     (WriteData),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic hi_expected(input logic [4:0] d);
        logic r;
        r = 1'b0;
`ifdef MULT_HI_WRITE_EN
        r = (d != 5'd31);
`endif
        return r;
    endfunction

    // Runs one operation from Start to idle; poke>0 re-asserts Start with other operands on that RUN edge
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] lo, input logic [31:0] hi, input int poke);
        int   spurious;
        logic hw;
        spurious = 0;
        hw = hi_expected(d);
        @(negedge Clk);
        Start = 1'b1; Signed = sgn; OperandA = a; OperandB = b; DestReg = d;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0; Signed = ~sgn; OperandA = ~a; OperandB = ~b; DestReg = ~d;
        chk({tag, " busy_after_start"}, 64'(Busy), 64'd1);
        for (int e = 1; e <= 31; e++) begin
            if (e == poke) begin
                Start = 1'b1; OperandA = 32'd2; OperandB = 32'd2; DestReg = 5'd3;
            end
            @(negedge Clk);
            Start = 1'b0;
            if (RegWrite || Done || !Busy || WriteData != 0 || WriteRegister != 0) spurious++;
        end
        chk({tag, " run_quiet"}, 64'(spurious), 64'd0);
        @(negedge Clk);
        chk({tag, " lo_regwrite"}, 64'(RegWrite), 64'd1);
        chk({tag, " lo_reg"}, 64'(WriteRegister), 64'(d));
        chk({tag, " lo_data"}, 64'(WriteData), 64'(lo));
        chk({tag, " lo_done"}, 64'(Done), 64'(!hw));
        if (hw) begin
            @(negedge Clk);
            chk({tag, " hi_regwrite"}, 64'(RegWrite), 64'd1);
            chk({tag, " hi_reg"}, 64'(WriteRegister), 64'(d + 5'd1));
            chk({tag, " hi_data"}, 64'(WriteData), 64'(hi));
            chk({tag, " hi_done"}, 64'(Done), 64'd1);
        end
        @(negedge Clk);
        chk({tag, " idle_outputs"}, {29'd0, Busy, Done, RegWrite, WriteData},
            {29'd0, 1'b0, 1'b0, 1'b0, 32'd0});
        chk({tag, " idle_reg"}, 64'(WriteRegister), 64'd0);
    endtask

    initial begin
        int          first;
        logic [31:0] seen;

        vecs[0]  = '{1'b0, 32'd3,         32'd5,         5'd7,  32'h0000000F, 32'h00000000};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd3,         5'd4,  32'hFFFFFFEB, 32'hFFFFFFFF};
        vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd10, 32'h00000001, 32'hFFFFFFFE};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd31, 32'h00000001, 32'hFFFFFFFE};
        vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  5'd2,  32'h80000000, 32'h00000000};
        vecs[5]  = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd0,  32'h00000001, 32'h00000000};
        vecs[6]  = '{1'b0, 32'h00010000,  32'h00010000,  5'd3,  32'h00000000, 32'h00000001};
        vecs[7]  = '{1'b1, 32'd5,         32'hFFFFFFFC,  5'd12, 32'hFFFFFFEC, 32'hFFFFFFFF};
        vecs[8]  = '{1'b0, 32'h80000000,  32'd2,         5'd1,  32'h00000000, 32'h00000001};
        vecs[9]  = '{1'b1, 32'h7FFFFFFF,  32'h7FFFFFFF,  5'd20, 32'h00000001, 32'h3FFFFFFF};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,  32'd2,         5'd30, 32'hFFFFFFFE, 32'h00000001};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset outputs", {29'd0, Busy, Done, RegWrite, WriteData}, 64'd0);
        chk("reset reg", 64'(WriteRegister), 64'd0);
        Reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].d,
                   vecs[i].lo, vecs[i].hi, 0);
        end

        // Start during RUN is ignored: 9 x 11 still lands unchanged
        run_op("start_while_busy", 1'b0, 32'd9, 32'd11, 5'd6, 32'd99, 32'd0, 10);

        // Reset mid-operation: immediate zero outputs, no write, then a clean 6 x 7
        @(negedge Clk);
        Start = 1'b1; Signed = 1'b0; OperandA = 32'h1234; OperandB = 32'h10; DestReg = 5'd9;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (14) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort outputs", {29'd0, Busy, Done, RegWrite, WriteData}, 64'd0);
        first = 0;
        repeat (3) begin
            @(negedge Clk);
            if (RegWrite || Busy) first++;
        end
        chk("abort quiet", 64'(first), 64'd0);
        Reset_n = 1'b1;
        run_op("after_abort", 1'b0, 32'd6, 32'd7, 5'd8, 32'h0000002A, 32'd0, 0);

        // Start held high: second operation is accepted on the first IDLE edge after completion
        @(negedge Clk);
        Start = 1'b1; Signed = 1'b0; OperandA = 32'd3; OperandB = 32'd3; DestReg = 5'd13;
        @(posedge Clk);
        @(negedge Clk);
        OperandA = 32'd4; OperandB = 32'd5; DestReg = 5'd20;
        first = -1;
        seen  = '0;
        for (int e = 1; e <= 80 && first < 0; e++) begin
            @(negedge Clk);
            if (RegWrite && WriteRegister == 5'd20 && WriteData == 32'd20) begin
                first = e;
                Start = 1'b0;
            end
            if (RegWrite && WriteRegister == 5'd13) seen = WriteData;
        end
        Start = 1'b0;
        chk("b2b first result", 64'(seen), 64'd9);
        chk("b2b second wb edge", 64'(first), hi_expected(5'd13) ? 64'd67 : 64'd66);
        repeat (4) @(negedge Clk);
        chk("b2b idle", {62'd0, Busy, RegWrite}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
